// File: rtl/outmap_feeder_if.sv
// Stream-in and compressor-facing signals of the output-map feeder.
// slave is the feeder side; master is the producer/compressor side.
interface outmap_feeder_if;
  logic [15:0][7:0] in_data;
  logic [4:0]       in_num;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [15:0][7:0] outmap_data;
  logic [4:0]       outmap_data_valid_num;
  logic             start;
  logic [4:0]       valid_taken_num;

  modport slave (
    input  in_data, in_num, in_valid, in_last, valid_taken_num,
    output in_ready, outmap_data, outmap_data_valid_num, start
  );

  modport master (
    output in_data, in_num, in_valid, in_last, valid_taken_num,
    input  in_ready, outmap_data, outmap_data_valid_num, start
  );
endinterface

// File: rtl/outmap_feeder.sv
// Byte shift buffer feeding the output-map compressor with a head-aligned
// 16-byte window; partial windows are released only once the map's last beat is in.
module outmap_feeder #(
  parameter int DEPTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  outmap_feeder_if.slave bus,
  output logic           map_done,
  output logic           take_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = DEPTH * 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            start_pend_q, start_pend_d;
  logic            map_done_q, map_done_d;
  logic            take_err_q, take_err_d;

  logic [4:0]      valid_num;
  logic [4:0]      take;
  logic [4:0]      num;
  logic            ready;
  logic            accept;
  logic            start_w;
  logic            over_take;
  logic [127:0]    beat_masked;
  logic [BW-1:0]   append;
  logic [CW-1:0]   keep_cnt;

  // Window visibility depends only on registered state, so the compressor may
  // derive valid_taken_num combinationally from it.
  always_comb begin
    valid_num = 5'd0;
    case (state_q)
      FILL:    valid_num = (cnt_q >= CW'(16)) ? 5'd16 : 5'd0;
      DRAIN:   valid_num = (cnt_q >= CW'(16)) ? 5'd16 : 5'(cnt_q);
      default: valid_num = 5'd0;
    endcase
    ready   = (cnt_q <= CW'(DEPTH - 16)) && (state_q != DRAIN);
    start_w = start_pend_q && (valid_num != 5'd0);
  end

  assign bus.in_ready              = ready;
  assign bus.outmap_data           = buf_q[127:0];
  assign bus.outmap_data_valid_num = valid_num;
  assign bus.start                 = start_w;
  assign map_done                  = map_done_q;
  assign take_err                  = take_err_q;

  // Bytes past cnt are kept zero, so appending is an OR into the shifted buffer.
  always_comb begin
    over_take = bus.valid_taken_num > valid_num;
    take      = over_take ? valid_num : bus.valid_taken_num;
    num       = (bus.in_num > 5'd16) ? 5'd16 : bus.in_num;
    accept    = bus.in_valid && ready;
    beat_masked = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < num) begin
        beat_masked[i*8 +: 8] = bus.in_data[i];
      end
    end
    keep_cnt = cnt_q - CW'(take);
    append   = {{(BW-128){1'b0}}, beat_masked} << {keep_cnt, 3'b000};
    buf_d    = (buf_q >> {take, 3'b000}) | (accept ? append : '0);
    cnt_d    = keep_cnt + (accept ? CW'(num) : CW'(0));
  end

  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q && !start_w;
    map_done_d   = 1'b0;
    take_err_d   = take_err_q || over_take;
    case (state_q)
      IDLE: begin
        if (accept) begin
          start_pend_d = 1'b1;
          state_d      = bus.in_last ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (accept && bus.in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // An empty map reaches here with start still pending; drop it silently.
        if (cnt_d == CW'(0)) begin
          state_d      = IDLE;
          map_done_d   = 1'b1;
          start_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      cnt_q        <= '0;
      start_pend_q <= 1'b0;
      map_done_q   <= 1'b0;
      take_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      start_pend_q <= start_pend_d;
      map_done_q   <= map_done_d;
      take_err_q   <= take_err_d;
    end
  end

endmodule
